// File: rtl/aes_byte_loader_if.sv
// Byte-stream and cipher-core signals of the AES byte loader.
// The slave modport is the loader's view; master is the view of the surrounding logic.
interface aes_byte_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         key_keep;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic [127:0] text_out;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;
  logic         err;

  modport slave (
    input  in_valid, in_data, key_keep, done, text_out, out_ready,
    output in_ready, ld, key, text_in, out_valid, out_data, busy, err
  );

  modport master (
    output in_valid, in_data, key_keep, done, text_out, out_ready,
    input  in_ready, ld, key, text_in, out_valid, out_data, busy, err
  );
endinterface

// File: rtl/aes_byte_loader.sv
// Packs a byte stream into a 128-bit key and block for an AES core, starts it,
// and streams the ciphertext back out byte by byte (MSB byte first).
//
// state     | meaning
// LOAD_KEY  | accepting 16 key bytes
// LOAD_TEXT | accepting 16 plaintext bytes
// START     | one-cycle ld pulse to the core
// WAIT      | waiting for done, bounded by TIMEOUT cycles
// SEND      | streaming 16 ciphertext bytes
module aes_byte_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  aes_byte_loader_if.slave bus
);

  localparam logic [2:0] LOAD_KEY  = 3'd0;
  localparam logic [2:0] LOAD_TEXT = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT      = 3'd3;
  localparam logic [2:0] SEND      = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]   state;
  logic [3:0]   idx;
  logic [7:0]   tmo_cnt;
  logic [127:0] key_q;
  logic [127:0] text_q;
  logic [127:0] result_q;
  logic         err_q;
  logic [6:0]   lsb;
  logic         in_xfer;
  logic         out_xfer;

  // Byte n lives at bits [127-8n -: 8]; for a 4-bit index, 15-n is just ~n.
  assign lsb      = {~idx, 3'b000};
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  assign bus.in_ready  = (state == LOAD_KEY) || (state == LOAD_TEXT);
  assign bus.ld        = (state == START);
  assign bus.busy      = (state == START) || (state == WAIT) || (state == SEND);
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = result_q[lsb +: 8];
  assign bus.key       = key_q;
  assign bus.text_in   = text_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD_KEY;
      idx      <= 4'd0;
      tmo_cnt  <= 8'd0;
      key_q    <= '0;
      text_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        LOAD_KEY: begin
          if (in_xfer) begin
            key_q[lsb +: 8] <= bus.in_data;
            idx             <= idx + 4'd1;
            if (idx == 4'd15) state <= LOAD_TEXT;
          end
        end
        LOAD_TEXT: begin
          if (in_xfer) begin
            text_q[lsb +: 8] <= bus.in_data;
            idx              <= idx + 4'd1;
            if (idx == 4'd15) state <= START;
          end
        end
        START: begin
          tmo_cnt <= 8'd0;
          state   <= WAIT;
        end
        WAIT: begin
          // done on the final counted cycle still wins over the timeout
          if (bus.done) begin
            result_q <= bus.text_out;
            idx      <= 4'd0;
            state    <= SEND;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q   <= 1'b1;
            idx     <= 4'd0;
            tmo_cnt <= 8'd0;
            state   <= LOAD_KEY;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        SEND: begin
          if (out_xfer) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= bus.key_keep ? LOAD_TEXT : LOAD_KEY;
          end
        end
        default: begin
          idx   <= 4'd0;
          state <= LOAD_KEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed bench for aes_byte_loader: a stub AES core answers known FIPS-197/SP800-38A
// vectors, expected ciphertext bytes are queued at issue and checked by a separate monitor.
module tb_aes_byte_loader;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_byte_loader_if bus();
  aes_byte_loader #(.TIMEOUT(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int popped = 0;
  int ld_count = 0;
  int err_count = 0;
  bit rand_ready = 0;
  bit gaps = 0;
  bit no_done = 0;
  bit spurious = 0;
  int core_lat = 2;
  logic [127:0] exp_key = '0;
  logic [127:0] exp_text = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each accepted byte, checks stall stability.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.err) err_count++;
      if (stall_prev && bus.out_valid) check("stall_hold", 128'(bus.out_data), 128'(data_prev));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %h expected none at %0t", bus.out_data, $time);
        end else begin
          check("out_byte", 128'(bus.out_data), 128'(exp_q.pop_front()));
          popped++;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Stub cipher core: answers by table lookup on the plaintext.
  initial begin
    logic [127:0] ct;
    bus.done     = 1'b0;
    bus.text_out = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ld) begin
        ld_count++;
        check("core_key", bus.key, exp_key);
        check("core_text", bus.text_in, exp_text);
        ct = (bus.text_in == PT2) ? CT2 : CT1;
        if (spurious) begin
          bus.done     = 1'b1;
          bus.text_out = ~ct;
        end
        @(posedge clk);
        #1 bus.done = 1'b0;
        @(negedge clk);
        check("ld_width", 128'(bus.ld), 128'(0));
        if (!no_done) begin
          repeat (core_lat) @(posedge clk);
          #1;
          bus.done     = 1'b1;
          bus.text_out = ct;
          @(posedge clk);
          #1;
          bus.done     = 1'b0;
          bus.text_out = '0;
        end
      end
    end
  end

  task automatic send16(input logic [127:0] v);
    for (int n = 0; n < 16; n++) begin
      int g;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = v[127 - 8*n -: 8];
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.in_ready && g < 50);
      if (!bus.in_ready) begin
        tests++;
        fails++;
        $display("FAIL in_ready_wait: got 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] t, input bit load_key,
                           input bit keep_next, input logic [127:0] ct, input bit expect_out,
                           input bit drain);
    int g;
    exp_key      = k;
    exp_text     = t;
    bus.key_keep = keep_next;
    if (expect_out) for (int n = 0; n < 16; n++) exp_q.push_back(ct[127 - 8*n -: 8]);
    if (load_key) send16(k);
    send16(t);
    @(negedge clk);
    check("ld_latency", 128'(bus.ld), 128'(1));
    if (drain) begin
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin @(negedge clk); g++; end
      check("drain_left", 128'(exp_q.size()), 128'(0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int wcnt;
    int p0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.key_keep = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_ld", 128'(bus.ld), 128'(0));
    check("rst_err", 128'(bus.err), 128'(0));
    check("rst_key", bus.key, 128'(0));
    check("rst_text", bus.text_in, 128'(0));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;

    spurious = 1;
    run_block(K, PT1, 1, 1, CT1, 1, 1);
    spurious = 0;

    run_block(K, PT2, 0, 0, CT2, 1, 1);
    check("key_kept", bus.key, K);

    gaps = 1;
    rand_ready = 1;
    run_block(K, PT1, 1, 0, CT1, 1, 1);
    gaps = 0;
    rand_ready = 0;

    core_lat = 9;
    run_block(K, PT2, 1, 0, CT2, 1, 1);
    check("no_err_boundary", 128'(err_count), 128'(0));
    core_lat = 2;

    no_done = 1;
    run_block(K, PT1, 1, 0, CT1, 0, 0);
    wcnt = 0;
    while (!bus.err && wcnt < 30) begin @(negedge clk); wcnt++; end
    check("err_delay", 128'(wcnt), 128'(11));
    check("err_in_ready", 128'(bus.in_ready), 128'(1));
    check("err_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    check("err_pulse_len", 128'(bus.err), 128'(0));
    check("err_count", 128'(err_count), 128'(1));
    no_done = 0;
    @(posedge clk);
    #1;

    p0 = popped;
    run_block(K, PT1, 1, 0, CT1, 1, 0);
    wcnt = 0;
    while (popped - p0 < 5 && wcnt < 200) begin @(negedge clk); wcnt++; end
    check("pre_rst_bytes", 128'(popped - p0), 128'(5));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_busy", 128'(bus.busy), 128'(0));
    check("mid_rst_key", bus.key, 128'(0));
    check("mid_rst_out_data", 128'(bus.out_data), 128'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    run_block(K, PT1, 1, 0, CT1, 1, 1);
    repeat (5) @(negedge clk);
    check("ld_total", 128'(ld_count), 128'(7));
    check("final_queue", 128'(exp_q.size()), 128'(0));
    check("final_err_count", 128'(err_count), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_byte_loader.md
AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in WAIT without done before error (1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_ready  output  1  loader accepts byte; transfer = in_valid && in_ready.
REQ-006 SHALL have port in_data  input  8  key/plaintext byte stream.
REQ-007 SHALL have port key_keep  input  1  sampled at end of SEND; 1 = reuse key for next block.
REQ-008 SHALL have port ld  output  1  single-cycle start pulse to cipher core.
REQ-009 SHALL have port key  output  128  assembled key to cipher core.
REQ-010 SHALL have port text_in  output  128  assembled plaintext to cipher core.
REQ-011 SHALL have port done  input  1  cipher core completion strobe.
REQ-012 SHALL have port text_out  input  128  ciphertext from core, valid when done=1.
REQ-013 SHALL have port out_valid  output  1  ciphertext byte valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid && out_ready.
REQ-015 SHALL have port out_data  output  8  ciphertext byte stream.
REQ-016 SHALL have port busy  output  1  high in START, WAIT, SEND.
REQ-017 SHALL have port err  output  1  one-cycle pulse on done timeout.

Function
REQ-018 SHALL implement FSM LOAD_KEY, LOAD_TEXT, START, WAIT, SEND; 4-bit byte index; 8-bit timeout counter.
REQ-019 Byte order SHALL be MSB first: byte n of a 16-byte group occupies bits [127-8n:120-8n], for key, text_in and out_data alike.
REQ-020 LOAD_KEY: in_ready=1; each transfer writes key byte; 16th transfer -> LOAD_TEXT, index cleared.
REQ-021 LOAD_TEXT: in_ready=1; each transfer writes text_in byte; 16th transfer -> START.
REQ-022 in_ready SHALL be 0 in START, WAIT, SEND; in_valid ignored there.
REQ-023 START: ld=1 for exactly that one cycle, then -> WAIT with timeout counter cleared.
REQ-024 key and text_in SHALL remain stable from START until next LOAD_KEY/LOAD_TEXT write.
REQ-025 WAIT: done=1 captures text_out into 128-bit result register, -> SEND, index cleared.
REQ-026 WAIT: counter increments each cycle without done; reaching TIMEOUT -> err=1 one cycle, -> LOAD_KEY; done in same cycle as timeout wins (capture, no err).
REQ-027 done outside WAIT (including the START cycle) SHALL be ignored.
REQ-028 SEND: out_valid=1, out_data = result byte[index]; index advances only on transfer; out_data stable while out_valid && !out_ready.
REQ-029 On 16th SEND transfer: key_keep=1 -> LOAD_TEXT (key retained); key_keep=0 -> LOAD_KEY.
REQ-030 Latency: ld asserts the cycle after the 32nd (or 16th with key kept) input transfer; first out_valid the cycle after done.
REQ-031 Gaps in in_valid / out_ready SHALL stall without loss, duplication or reorder.

Reset
REQ-032 rst=1 SHALL immediately force LOAD_KEY, index=0, counter=0, ld=0, out_valid=0, err=0, busy=0, in_ready=1 on release, key=0, text_in=0, result=0, out_data=0.
REQ-033 Reset mid-operation (any state) SHALL discard partial block; no ld or out byte follows until a full new block is loaded.

Verification
REQ-034 Reset: assert rst mid-cycle -> outputs take REQ-032 values asynchronously; in_ready=1 first cycle after release.
REQ-035 Vector: key 2b7e151628aed2a6abf7158809cf4f3c, text 6bc1bee22e409f96e93d7e117393172a, real cipher core -> one ld pulse, out bytes 3a d7 7b b4 0d 7a 36 60 a8 9e ca f3 24 66 ef 97.
REQ-036 key_keep=1 then 16 bytes ae2d8a571e03ac9c9eb76fac45af8e51 -> key unchanged, out f5d3d58503b9699de785895a96fdbaaf.
REQ-037 Random in_valid gaps and out_ready toggling on REQ-035 vector -> identical byte stream, out_data stable during stalls.
REQ-038 Core model never asserts done, TIMEOUT=10 -> err pulse exactly 10 cycles after WAIT entry, state LOAD_KEY, in_ready=1.
REQ-039 rst during SEND after 5 bytes -> out_valid=0 immediately; subsequent full vector yields correct 16 bytes only.
